progmem_loader: RTL
===================

// Module: progmem_loader
// PURPOSE
//  Write side of the program-memory interface: receives a framed byte stream, assembles
//  32-bit instruction words and writes them into program memory while holding the CPU
//  halted. Sits between a host byte source (UART/debug link) and the progmem write port;
//  the CPU only fetches after this block reports a clean load.
// PARAMETERS
//  ADDR_WIDTH    8     progmem word-address width; max words = 2**ADDR_WIDTH
//  START_BYTE    8'hA5 frame start marker
//  CHECK_OPCODE  1     1 = reject words whose opcode [4:0] is reserved (0 or 26..31)
// PORTS
//  clk         in   1           system clock, rising edge
//  rst         in   1           synchronous reset, active-high
//  in_data     in   8           received byte
//  in_valid    in   1           in_data valid this cycle
//  in_ready    out  1           block accepts a byte this cycle (byte taken when valid&ready)
//  mem_we      out  1           progmem write strobe, one-cycle pulse per word
//  mem_addr    out  ADDR_WIDTH  progmem word address
//  mem_wdata   out  32          instruction word
//  cpu_hold    out  1           1 = CPU held in reset/halt
//  done        out  1           last frame loaded, checksum good
//  error       out  1           last frame aborted
//  word_count  out  ADDR_WIDTH+1  words written in current/last frame
// BEHAVIOUR
//  Frame: START_BYTE, LEN_LO, LEN_HI (16-bit word count N, little-endian),
//   4*N data bytes (each word little-endian: first byte -> [7:0]), CHK byte.
//   CHK = XOR of all 4*N data bytes (0x00 when N=0).
//  Reset: state IDLE; in_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; cpu_hold=1;
//   done=0; error=0; word_count=0; checksum acc=0. Reset mid-frame discards the frame;
//   words already written stay in progmem but done stays 0.
//  in_ready=1 in every state (no backpressure); a byte is consumed only when in_valid=1.
//  FSM (all transitions on an accepted byte unless stated):
//   IDLE/DONE/ERROR: byte==START_BYTE -> LEN_LO; clear done,error,word_count,acc,
//    byte index; cpu_hold=1. Any other byte discarded, state unchanged.
//   LEN_LO: latch N[7:0] -> LEN_HI.
//   LEN_HI: latch N[15:8]; N > 2**ADDR_WIDTH -> ERROR (no writes); N==0 -> CHECK;
//    else -> DATA.
//   DATA: shift byte into word at index 0..3, acc ^= byte. On 4th byte: if CHECK_OPCODE
//    and opcode reserved -> ERROR, no write; else next cycle mem_we=1, mem_addr=word_count
//    [ADDR_WIDTH-1:0], mem_wdata=word, word_count++. Word count reaching N -> CHECK.
//   CHECK: byte==acc -> DONE (done=1, cpu_hold=0 next cycle); else -> ERROR.
//  Write latency: mem_we asserts exactly 1 cycle after the 4th byte of a word is accepted;
//   mem_addr/mem_wdata held stable until the next write. A new byte accepted in the same
//   cycle as mem_we is processed normally (back-to-back words every 4 cycles min).
//  ERROR: error=1, cpu_hold stays 1 until a later frame reaches DONE.
//  DONE: done=1 and cpu_hold=0 until START_BYTE accepted again or rst.
//  Address wraps never: N bound check guarantees mem_addr <= 2**ADDR_WIDTH-1.
//  START_BYTE value inside LEN/DATA/CHK is ordinary data, never a resync.
// TESTING
//  1 Bytes A5 02 00 66 56 34 12 13 00 00 00 05 -> writes [0]=0x12345666, [1]=0x00000013,
//    word_count=2, done=1, cpu_hold=0 one cycle after CHK, error=0.
//  2 Same frame with CHK=06 -> both words written, error=1, done=0, cpu_hold=1.
//  3 A5 00 00 00 -> no mem_we, done=1, word_count=0, cpu_hold=0.
//  4 A5 01 00 1F 00 00 00 (CHECK_OPCODE=1) -> error=1 after 4th data byte, no mem_we;
//    CHECK_OPCODE=0 same bytes + CHK 1F -> [0]=0x0000001F, done=1.
//  5 A5 01 01 (N=257, ADDR_WIDTH=8) -> error=1 right after LEN_HI, no writes;
//    then frame of test 1 -> done=1 (recovery from ERROR).
//  6 rst pulsed after 6 data bytes of test 1 -> all outputs at reset values, state IDLE;
//    stray bytes 00 FF ignored; in_valid gaps mid-word don't change assembled words.

Source files
------------

// File: rtl/progmem_loader.sv
// Program-memory loader: parses framed byte stream, assembles 32-bit words,
// writes them to progmem and holds the CPU until a frame loads cleanly.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_data, in_valid   host byte stream (byte taken when in_valid & in_ready)
//   in_ready            always 1, no backpressure
//   mem_we              one-cycle write strobe per assembled word
//   mem_addr, mem_wdata word address / instruction word, held until next write
//   cpu_hold            1 while CPU must stay halted
//   done, error         last frame loaded cleanly / aborted
//   word_count          words written in current or last frame
module progmem_loader #(
   parameter int         ADDR_WIDTH   = 8,
   parameter logic [7:0] START_BYTE   = 8'hA5,
   parameter bit         CHECK_OPCODE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t      state;
   logic [15:0] len;
   logic [31:0] word;
   logic [1:0]  byte_idx;
   logic [7:0]  acc;

   logic [31:0] word_next;
   logic [15:0] len_next;
   logic        op_bad;
   logic        last_word;
   logic        too_long;

   assign in_ready = 1'b1;

   always_comb begin
      word_next = word;
      word_next[{byte_idx, 3'b000} +: 8] = in_data;
      len_next  = {in_data, len[7:0]};
      op_bad    = CHECK_OPCODE &&
                  ((word_next[4:0] == 5'd0) || (word_next[4:0] >= 5'd26));
      last_word = (32'(word_count) + 32'd1) == 32'(len);
      too_long  = 32'(len_next) > MAX_WORDS;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         len        <= '0;
         word       <= '0;
         byte_idx   <= '0;
         acc        <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
      end else begin
         mem_we <= 1'b0;
         if (in_valid) begin
            unique case (state)
               S_IDLE, S_DONE, S_ERROR: begin
                  if (in_data == START_BYTE) begin
                     state      <= S_LEN_LO;
                     done       <= 1'b0;
                     error      <= 1'b0;
                     word_count <= '0;
                     acc        <= '0;
                     byte_idx   <= '0;
                     cpu_hold   <= 1'b1;
                  end
               end
               S_LEN_LO: begin
                  len[7:0] <= in_data;
                  state    <= S_LEN_HI;
               end
               S_LEN_HI: begin
                  len[15:8] <= in_data;
                  if (too_long) begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end else if (len_next == 16'd0) begin
                     state <= S_CHECK;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  acc      <= acc ^ in_data;
                  word     <= word_next;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     if (op_bad) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                     end else begin
                        mem_we     <= 1'b1;
                        mem_addr   <= word_count[ADDR_WIDTH-1:0];
                        mem_wdata  <= word_next;
                        word_count <= word_count + 1'b1;
                        if (last_word) state <= S_CHECK;
                     end
                  end
               end
               S_CHECK: begin
                  if (in_data == acc) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
